cam_cfg_sequencer: RTL and testbench
====================================

Name: cam_cfg_sequencer

Overview:
Walks a multi-profile OV7670 configuration table and issues register writes to the SCCB master over a valid/ready handshake. It decodes in-table millisecond delay markers and the end marker, and retries writes that are NACKed. It sits between the top-level start/profile controls and the SCCB master, and supersedes the fixed single-table configuration ROM. Table contents live in the sub-module cam_cfg_table.

Parameters:
N_PROFILES, 2, number of selectable configuration tables (profile 0 = RGB444, profile 1 = RGB565).
IDX_W, 8, table index width; max table depth 2**IDX_W entries.
CLK_HZ, 25_000_000, i_clk frequency, used for the ms tick.
MAX_RETRY, 3, re-send attempts per entry after a NACK before error.
PROF_W, $clog2(N_PROFILES) (min 1), derived width of i_profile.

Ports:
i_clk  in  1  system clock
i_rstn  in  1  asynchronous active-low reset
i_start  in  1  one-cycle pulse; begin configuration (ignored unless IDLE/DONE/ERROR)
i_profile  in  PROF_W  table select, sampled on accepted i_start
i_sccb_ready  in  1  SCCB master can accept a write
i_sccb_done  in  1  one-cycle pulse; current write finished
i_sccb_nack  in  1  qualifies i_sccb_done; write was not acknowledged
o_sccb_valid  out  1  write request valid
o_sccb_addr  out  8  OV7670 register address
o_sccb_data  out  8  register value
o_busy  out  1  sequence in progress
o_done  out  1  level; sequence completed successfully
o_err  out  1  level; sequence aborted after retries
o_idx  out  IDX_W  current table index (debug)

Behaviour:
- Reset: one clock i_clk; reset is asynchronous and active-low on i_rstn. All outputs reset to 0; state IDLE; counters 0.
- Entry format is 16 bits, {addr[15:8], data[7:0]}:
  - 0xFFFF = end.
  - 0xFFdd with dd != 0xFF = delay of dd ms; dd = 0 means no wait.
  - Anything else = register write.
- cam_cfg_table read latency is 1 cycle (registered output).
- FSM:
  - IDLE/DONE/ERROR: on i_start, latch profile, idx<=0, clear o_done/o_err, set o_busy, go FETCH.
  - FETCH: present idx to table; go DECODE next cycle (covers the ROM latency).
  - DECODE:
    - End marker -> DONE.
    - Delay -> DELAY, load ms counter = dd.
    - Write -> SEND, with o_sccb_addr/o_sccb_data loaded from the entry.
  - SEND: o_sccb_valid=1; addr/data held stable until i_sccb_ready is sampled high. Transfer occurs in that cycle; valid drops next cycle; go WAIT_ACK.
  - WAIT_ACK: wait for i_sccb_done.
    - No NACK -> retry counter = 0, idx+1, FETCH.
    - NACK and retries < MAX_RETRY -> retries+1, back to SEND with the same entry.
    - NACK and retries = MAX_RETRY -> ERROR.
  - DELAY: tick counter counts CLK_HZ/1000 cycles per ms. When ms counter reaches 0 -> idx+1, FETCH. dd = 0 exits after exactly 1 cycle.
  - DONE: o_done=1, o_busy=0. ERROR: o_err=1, o_busy=0, o_idx holds the failing index.
- Index overflow: if idx = 2**IDX_W-1 is consumed without an end marker, the sequencer goes to DONE; the index never wraps.
- i_start while busy: ignored. i_profile changes while busy: ignored.
- i_sccb_done outside WAIT_ACK: ignored.
- Reset mid-transaction: immediate return to IDLE; o_sccb_valid drops asynchronously.
- Per-write overhead excluding the SCCB handshake: FETCH + DECODE = 2 cycles.

Decomposition:
- Package cam_cfg_pkg holds:
  - CFG_END (16'hFFFF), CFG_DLY_ADDR (8'hFF)
  - state encoding localparams (IDLE, FETCH, DECODE, SEND, WAIT_ACK, DELAY, DONE, ERROR)
  - function ticks_per_ms(CLK_HZ)
- One sub-module, cam_cfg_table:
  - Inputs i_clk, i_rstn, profile, idx; output 16-bit entry, 1-cycle latency.
  - Out-of-range index or profile returns CFG_END.
  - Profile 0 begins 12_80, FF_F0, 12_04, 11_00. Profile 1 begins 12_80, FF_F0, 12_04, 8C_00, 40_D0.

Test Plan:
- Bench setup: CLK_HZ=10_000 (10 cycles/ms); SCCB model with ready always 1 and done 5 cycles after the transfer.
- Profile 0 start -> first transfer 0x12/0x80. Next transfer 0x12/0x04 occurs no earlier than 2400 cycles later (0xF0 = 240 ms delay). The sequence ends with o_done=1, o_busy=0, with one transfer per non-marker entry.
- Ready held low for 7 cycles during SEND -> o_sccb_valid stays 1 with addr/data unchanged; exactly one transfer occurs when ready rises.
- NACK on the first write twice, then ACK -> 0x12/0x80 is sent 3 times, then the sequence proceeds normally. NACK 4 times (MAX_RETRY=3) -> o_err=1, o_idx=0, no further transfers.
- Table entry FF_00 -> DELAY lasts 1 cycle, then the next entry is fetched; no SCCB transfer is issued for it.
- i_rstn asserted during WAIT_ACK of entry 5 -> all outputs 0 immediately. A new i_start with profile 1 restarts at idx 0 with 0x12/0x80.
- i_start pulsed while busy -> no effect on idx or the transfer sequence. i_start in DONE -> clean rerun with o_done cleared on the accepting cycle.

Source files
------------

// File: rtl/cam_cfg_pkg.sv
// Shared definitions for the OV7670 configuration sequencer.
// Entry format is {addr[15:8], data[7:0]}:
//   CFG_END         terminates a table
//   {CFG_DLY_ADDR,dd} waits dd milliseconds (dd = 0 is a no-op)
//   anything else   is a register write
package cam_cfg_pkg;

    localparam logic [15:0] CFG_END      = 16'hFFFF;
    localparam logic [7:0]  CFG_DLY_ADDR = 8'hFF;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_DECODE   = 3'd2,
        ST_SEND     = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_DELAY    = 3'd5,
        ST_DONE     = 3'd6,
        ST_ERROR    = 3'd7
    } cfg_state_e;

    // Clock cycles per millisecond; never returns 0 so slow clocks still advance.
    function automatic int ticks_per_ms(input int clk_hz);
        int t;
        t = clk_hz / 1000;
        return (t < 1) ? 1 : t;
    endfunction

endpackage

// File: rtl/cam_cfg_table.sv
// Multi-profile OV7670 configuration tables, one registered read port.
// Ports:
//   i_clk, i_rstn  clock, async active-low reset
//   i_profile      table select
//   i_idx          entry index
//   o_entry        {addr, data} for (i_profile, i_idx), valid one cycle later
// Unknown profiles and indices past a table's end read back CFG_END.
module cam_cfg_table
    import cam_cfg_pkg::*;
#(
    parameter int N_PROFILES = 2,
    parameter int IDX_W      = 8,
    parameter int PROF_W     = 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [PROF_W-1:0] i_profile,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [15:0]       o_entry
);

    logic [15:0] entry_d;
    logic [15:0] entry_q;
    int          prof_n;
    int          idx_n;

    always_comb begin
        entry_d = CFG_END;
        prof_n  = 32'(i_profile);
        idx_n   = 32'(i_idx);
        if (prof_n < N_PROFILES) begin
            case (prof_n)
                // RGB444
                0: begin
                    case (idx_n)
                        0:       entry_d = 16'h1280;  // COM7 soft reset
                        1:       entry_d = 16'hFFF0;  // 240 ms settle after reset
                        2:       entry_d = 16'h1204;
                        3:       entry_d = 16'h1100;
                        4:       entry_d = 16'h8C02;
                        5:       entry_d = 16'h40D0;
                        6:       entry_d = 16'h3A04;
                        default: entry_d = CFG_END;
                    endcase
                end
                // RGB565
                1: begin
                    case (idx_n)
                        0:       entry_d = 16'h1280;
                        1:       entry_d = 16'hFFF0;
                        2:       entry_d = 16'h1204;
                        3:       entry_d = 16'h8C00;
                        4:       entry_d = 16'h40D0;
                        5:       entry_d = 16'h3A04;
                        6:       entry_d = 16'hFF00;
                        7:       entry_d = 16'h3DC0;
                        default: entry_d = CFG_END;
                    endcase
                end
                default: entry_d = CFG_END;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            entry_q <= CFG_END;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign o_entry = entry_q;

endmodule

// File: rtl/cam_cfg_sequencer.sv
// OV7670 configuration sequencer: walks a selected table and hands each
// register write to the SCCB master over valid/ready, honouring in-table
// millisecond delays and retrying NACKed writes.
// Ports:
//   i_clk, i_rstn                  clock, async active-low reset
//   i_start, i_profile             start pulse and table select
//   i_sccb_ready/done/nack         SCCB master handshake and completion
//   o_sccb_valid/addr/data         write request
//   o_busy, o_done, o_err, o_idx   status and current table index
//
// state    | meaning
// IDLE     | waiting for i_start after reset
// FETCH    | index presented to table, waiting out read latency
// DECODE   | classify entry: end, delay or write
// SEND     | write request valid, waiting for ready
// WAIT_ACK | write accepted, waiting for done/nack
// DELAY    | counting down ms
// DONE     | table completed
// ERROR    | write failed after all retries, o_idx points at it
module cam_cfg_sequencer
    import cam_cfg_pkg::*;
#(
    parameter int N_PROFILES = 2,
    parameter int IDX_W      = 8,
    parameter int CLK_HZ     = 25_000_000,
    parameter int MAX_RETRY  = 3,
    parameter int PROF_W     = (N_PROFILES > 1) ? $clog2(N_PROFILES) : 1
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_start,
    input  logic [PROF_W-1:0] i_profile,
    input  logic              i_sccb_ready,
    input  logic              i_sccb_done,
    input  logic              i_sccb_nack,
    output logic              o_sccb_valid,
    output logic [7:0]        o_sccb_addr,
    output logic [7:0]        o_sccb_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [IDX_W-1:0]  o_idx
);

    localparam int TICKS  = ticks_per_ms(CLK_HZ);
    localparam int TICK_W = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int RTRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICKS - 1);
    localparam logic [RTRY_W-1:0] RETRY_LIMIT = RTRY_W'(MAX_RETRY);
    localparam logic [IDX_W-1:0]  IDX_LAST    = '1;

    cfg_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [PROF_W-1:0] prof_q, prof_d;
    logic [RTRY_W-1:0] retry_q, retry_d;
    logic [7:0]        ms_q, ms_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [7:0]        addr_q, addr_d;
    logic [7:0]        data_q, data_d;
    logic              advance;
    logic [15:0]       entry;

    cam_cfg_table #(
        .N_PROFILES (N_PROFILES),
        .IDX_W      (IDX_W),
        .PROF_W     (PROF_W)
    ) u_table (
        .i_clk     (i_clk),
        .i_rstn    (i_rstn),
        .i_profile (prof_q),
        .i_idx     (idx_q),
        .o_entry   (entry)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        prof_d  = prof_q;
        retry_d = retry_q;
        ms_d    = ms_q;
        tick_d  = tick_q;
        addr_d  = addr_q;
        data_d  = data_q;
        advance = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    prof_d  = i_profile;
                    idx_d   = '0;
                    retry_d = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                if (entry == CFG_END) begin
                    state_d = ST_DONE;
                end else if (entry[15:8] == CFG_DLY_ADDR) begin
                    ms_d    = entry[7:0];
                    tick_d  = TICK_RELOAD;
                    state_d = ST_DELAY;
                end else begin
                    addr_d  = entry[15:8];
                    data_d  = entry[7:0];
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (i_sccb_ready) begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                if (i_sccb_done) begin
                    if (!i_sccb_nack) begin
                        retry_d = '0;
                        advance = 1'b1;
                    end else if (retry_q < RETRY_LIMIT) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_SEND;
                    end else begin
                        state_d = ST_ERROR;
                    end
                end
            end
            ST_DELAY: begin
                // Terminal count checked first so dd = 0 leaves after one cycle.
                if (ms_q == 8'd0) begin
                    advance = 1'b1;
                end else if (tick_q == '0) begin
                    ms_d   = ms_q - 8'd1;
                    tick_d = TICK_RELOAD;
                end else begin
                    tick_d = tick_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A table without an end marker finishes at the last index instead of wrapping.
        if (advance) begin
            if (idx_q == IDX_LAST) begin
                state_d = ST_DONE;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = ST_FETCH;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            prof_q  <= '0;
            retry_q <= '0;
            ms_q    <= '0;
            tick_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            prof_q  <= prof_d;
            retry_q <= retry_d;
            ms_q    <= ms_d;
            tick_q  <= tick_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    // Status decoded straight from the state register so reset clears them asynchronously.
    assign o_sccb_valid = (state_q == ST_SEND);
    assign o_sccb_addr  = addr_q;
    assign o_sccb_data  = data_q;
    assign o_busy       = (state_q == ST_FETCH) || (state_q == ST_DECODE) ||
                          (state_q == ST_SEND)  || (state_q == ST_WAIT_ACK) ||
                          (state_q == ST_DELAY);
    assign o_done       = (state_q == ST_DONE);
    assign o_err        = (state_q == ST_ERROR);
    assign o_idx        = idx_q;

endmodule

// File: tb/tb_cam_cfg_sequencer.sv
// Directed bench for cam_cfg_sequencer at CLK_HZ = 10_000 (10 cycles per ms).
// SCCB responder: done pulses 5 cycles after each transfer, optionally NACKed.
module tb_cam_cfg_sequencer;

    logic       clk = 1'b0;
    logic       rstn;
    logic       start;
    logic [0:0] profile;
    logic       ready;
    logic       done_p;
    logic       nack_p;
    logic       o_sccb_valid;
    logic [7:0] o_sccb_addr;
    logic [7:0] o_sccb_data;
    logic       o_busy;
    logic       o_done;
    logic       o_err;
    logic [7:0] o_idx;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    logic [15:0] xlog [0:127];
    int          xcyc [0:127];
    int          xn          = 0;
    int          done_cnt    = 0;
    int          nack_target = 0;
    int          nack_issued = 0;

    cam_cfg_sequencer #(
        .CLK_HZ (10_000)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_start      (start),
        .i_profile    (profile),
        .i_sccb_ready (ready),
        .i_sccb_done  (done_p),
        .i_sccb_nack  (nack_p),
        .o_sccb_valid (o_sccb_valid),
        .o_sccb_addr  (o_sccb_addr),
        .o_sccb_data  (o_sccb_data),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_err        (o_err),
        .o_idx        (o_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SCCB master model; inputs are stable at the falling edge, so a transfer
    // seen here happens at the following rising edge.
    initial begin
        done_p = 1'b0;
        nack_p = 1'b0;
        forever begin
            @(negedge clk);
            done_p = 1'b0;
            nack_p = 1'b0;
            if (!rstn) begin
                done_cnt = 0;
            end else begin
                if (done_cnt != 0) begin
                    done_cnt--;
                    if (done_cnt == 0) begin
                        done_p = 1'b1;
                        if (nack_issued < nack_target) begin
                            nack_p = 1'b1;
                            nack_issued++;
                        end
                    end
                end
                if (o_sccb_valid && ready) begin
                    if (xn < 128) begin
                        xlog[xn] = {o_sccb_addr, o_sccb_data};
                        xcyc[xn] = cyc;
                    end
                    xn++;
                    done_cnt = 5;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start(input logic p, output int c);
        profile = p;
        start   = 1'b1;
        c       = cyc;
        step();
        start   = 1'b0;
    endtask

    task automatic wait_xfers(input int n, input int budget, input string tag);
        int k = 0;
        while (xn < n && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(xn >= n), 1);
    endtask

    task automatic wait_end(input int budget, input string tag);
        int k = 0;
        while (!o_done && !o_err && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(o_done | o_err), 1);
    endtask

    initial begin
        int b;
        int c;

        rstn    = 1'b0;
        start   = 1'b0;
        profile = 1'b0;
        ready   = 1'b1;
        repeat (3) step();
        check("reset_outs", 32'({o_sccb_valid, o_sccb_addr, o_sccb_data,
                                 o_busy, o_done, o_err, o_idx}), 0);
        rstn = 1'b1;
        step();

        // Profile 0 full run
        b = xn;
        pulse_start(1'b0, c);
        wait_xfers(b + 1, 50, "p0_first_wait");
        check("p0_first_xfer", 32'(xlog[b]), 'h1280);
        check("p0_first_lat", xcyc[b] - c, 3);
        check("p0_busy", 32'(o_busy), 1);
        wait_xfers(b + 2, 3000, "p0_second_wait");
        check("p0_second_xfer", 32'(xlog[b + 1]), 'h1204);
        check("p0_delay_gap", xcyc[b + 1] - xcyc[b], 2411);
        wait_end(500, "p0_end_wait");
        check("p0_count", xn - b, 6);
        check("p0_third_xfer", 32'(xlog[b + 2]), 'h1100);
        check("p0_last_xfer", 32'(xlog[b + 5]), 'h3A04);
        check("p0_flags", 32'({o_done, o_busy, o_err, o_sccb_valid}), 'b1000);
        check("p0_idx", 32'(o_idx), 7);

        // Rerun from DONE with ready stalled for 7 cycles
        ready = 1'b0;
        b = xn;
        pulse_start(1'b0, c);
        check("rerun_done_clr", 32'({o_done, o_busy}), 'b01);
        step();
        step();
        for (int i = 0; i < 7; i++) begin
            check("stall_hold", 32'({o_sccb_valid, o_sccb_addr, o_sccb_data}), 'h11280);
            step();
        end
        check("stall_no_xfer", xn - b, 0);
        ready = 1'b1;
        step();
        check("stall_one_xfer", xn - b, 1);
        check("stall_valid_drop", 32'(o_sccb_valid), 0);
        check("stall_xfer_val", 32'(xlog[b]), 'h1280);
        wait_end(3000, "stall_end_wait");
        check("stall_count", xn - b, 6);

        // Two NACKs then ACK on the first write
        nack_target = nack_issued + 2;
        b = xn;
        pulse_start(1'b0, c);
        wait_xfers(b + 4, 3000, "nack2_wait");
        check("nack2_send1", 32'(xlog[b]), 'h1280);
        check("nack2_send2", 32'(xlog[b + 1]), 'h1280);
        check("nack2_send3", 32'(xlog[b + 2]), 'h1280);
        check("nack2_next", 32'(xlog[b + 3]), 'h1204);
        check("nack2_resend_gap", xcyc[b + 1] - xcyc[b], 6);
        wait_end(3000, "nack2_end_wait");
        check("nack2_flags", 32'({o_done, o_err}), 'b10);
        check("nack2_count", xn - b, 8);

        // Four NACKs exhaust the retries
        nack_target = nack_issued + 4;
        b = xn;
        pulse_start(1'b0, c);
        wait_end(200, "nack4_end_wait");
        check("nack4_flags", 32'({o_err, o_done, o_busy}), 'b100);
        check("nack4_idx", 32'(o_idx), 0);
        check("nack4_sends", xn - b, 4);
        repeat (20) step();
        check("nack4_quiet", xn - b, 4);

        // Profile 1, includes a zero-length delay entry
        b = xn;
        pulse_start(1'b1, c);
        wait_end(3000, "p1_end_wait");
        check("p1_count", xn - b, 6);
        check("p1_xfer3", 32'(xlog[b + 2]), 'h8C00);
        check("p1_plain_gap", xcyc[b + 3] - xcyc[b + 2], 8);
        check("p1_before_dly0", 32'(xlog[b + 4]), 'h3A04);
        check("p1_after_dly0", 32'(xlog[b + 5]), 'h3DC0);
        check("p1_dly0_gap", xcyc[b + 5] - xcyc[b + 4], 11);
        check("p1_flags", 32'({o_done, o_err}), 'b10);

        // Reset while waiting for the ack of entry 5
        b = xn;
        pulse_start(1'b0, c);
        wait_xfers(b + 5, 3000, "rst_wait");
        check("rst_pre_xfer", 32'(xlog[b + 4]), 'h40D0);
        check("rst_pre_state", 32'({o_idx, o_busy, o_sccb_valid}), 'h16);
        rstn = 1'b0;
        #1;
        check("rst_async", 32'({o_sccb_valid, o_sccb_addr, o_sccb_data,
                                o_busy, o_done, o_err, o_idx}), 0);
        step();
        rstn = 1'b1;
        step();

        // Restart with profile 1, start pulses while busy are ignored
        b = xn;
        pulse_start(1'b1, c);
        wait_xfers(b + 1, 50, "restart_wait");
        check("restart_xfer", 32'(xlog[b]), 'h1280);
        check("restart_lat", xcyc[b] - c, 3);
        profile = 1'b0;
        start   = 1'b1;
        step();
        start   = 1'b0;
        repeat (10) step();
        check("busy_start_idx", 32'(o_idx), 1);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_end(3000, "busy_end_wait");
        check("busy_count", xn - b, 6);
        check("busy_xfer2", 32'(xlog[b + 1]), 'h1204);
        check("busy_xfer3", 32'(xlog[b + 2]), 'h8C00);
        check("busy_flags", 32'({o_done, o_err, o_idx}), 'h208);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
